// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction-timer score path: the sequencer state
// encoding and the fixed register-file addresses.
//   REG_COUNT      : register holding the number of recorded runs
//   REG_BEST       : register holding the best (lowest non-zero) time
//   REG_FIRST_SLOT : first rotating score slot
//   SCORE_W        : default data width of the register file
// -----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_SCORE = 2'd1,
        W_COUNT = 2'd2,
        W_BEST  = 2'd3
    } state_t;

    localparam logic [2:0] REG_COUNT      = 3'd0;
    localparam logic [2:0] REG_BEST       = 3'd7;
    localparam logic [2:0] REG_FIRST_SLOT = 3'd1;
    localparam int         SCORE_W        = 13;

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// 3-bit up counter that runs start..wrap and then returns to start.
// A synchronous clear also loads start, so the counter never holds a value
// outside its programmed range.
// Ports:
//   clk   in  1  rising-edge clock
//   clr_n in  1  synchronous active-low clear (loads start)
//   en    in  1  advance by one this cycle
//   start in  3  first value of the range
//   wrap  in  3  last value of the range
//   count out 3  current value
// -----------------------------------------------------------------------------
module wrap_counter (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic [2:0] start,
    input  logic [2:0] wrap,
    output logic [2:0] count
);

    // >= rather than == so a value past wrap (e.g. wrap lowered at run time)
    // still returns to start instead of running through 7 and 0.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= start;
        end else if (en) begin
            count <= (count >= wrap) ? start : count + 3'd1;
        end
    end

endmodule

// File: rtl/score_bank_sequencer.sv
// -----------------------------------------------------------------------------
// score_bank_sequencer
// Sequences every write into the 8 x W score register file and chooses the
// address of its display read port.  Each accepted reaction time produces up
// to three one-cycle writes: the score into a rotating slot (1..NSLOTS), the
// incremented run count into reg0, and, when it improves on the record, the
// score into reg7.  Between runs the display address steps through the slots
// and then the best-time register.
// Ports:
//   Clock       in   1  system clock, all flops on the rising edge
//   CLRN        in   1  synchronous active-low reset
//   score_valid in   1  pulse: score_in holds a finished reaction time
//   score_in    in   W  reaction time in ms, taken only while ready=1
//   view_next   in   1  pulse: advance the displayed slot
//   DATAP       in   W  register-file port P (reads reg0, the run count)
//   WR          out  1  register-file write enable (registered)
//   WA          out  3  register-file write address (registered)
//   LD_DATA     out  W  register-file write data (registered)
//   RQ          out  3  register-file read address Q for the displays
//   ready       out  1  a new score may be offered
//   dropped     out  1  pulse: a score arrived while busy and was discarded
//   best        out  W  copy of reg7, 0 when no run has been recorded
// -----------------------------------------------------------------------------
module score_bank_sequencer
    import reaction_pkg::*;
#(
    parameter int NSLOTS = 4,
    parameter int W      = SCORE_W
) (
    input  logic         Clock,
    input  logic         CLRN,
    input  logic         score_valid,
    input  logic [W-1:0] score_in,
    input  logic         view_next,
    input  logic [W-1:0] DATAP,
    output logic         WR,
    output logic [2:0]   WA,
    output logic [W-1:0] LD_DATA,
    output logic [2:0]   RQ,
    output logic         ready,
    output logic         dropped,
    output logic [W-1:0] best
);

    localparam logic [2:0]   LAST_SLOT      = 3'(NSLOTS);
    // The view counter runs one step past the last slot; that extra code is
    // shown as the best-time register.
    localparam logic [2:0]   VIEW_BEST_CODE = 3'(NSLOTS + 1);
    localparam logic [W-1:0] COUNT_MAX      = '1;

    state_t       state;
    state_t       state_d;
    logic [W-1:0] s_reg;
    logic [2:0]   slot_ptr;
    logic [2:0]   view_cnt;
    logic [2:0]   view_ptr;
    logic [2:0]   rq_hold;
    logic [W-1:0] count_inc;
    logic         new_best;
    logic         wr_d;
    logic [2:0]   wa_d;
    logic [W-1:0] ld_d;

    // -------------------------------------------------------------------------
    // Slot and view pointers
    // -------------------------------------------------------------------------
    wrap_counter u_slot_ptr (
        .clk   (Clock),
        .clr_n (CLRN),
        .en    (state == W_SCORE),
        .start (REG_FIRST_SLOT),
        .wrap  (LAST_SLOT),
        .count (slot_ptr)
    );

    wrap_counter u_view_ptr (
        .clk   (Clock),
        .clr_n (CLRN),
        .en    (view_next),
        .start (REG_FIRST_SLOT),
        .wrap  (VIEW_BEST_CODE),
        .count (view_cnt)
    );

    assign view_ptr = (view_cnt == VIEW_BEST_CODE) ? REG_BEST : view_cnt;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    // The run count sticks at full scale instead of wrapping back to zero.
    assign count_inc = (DATAP == COUNT_MAX) ? COUNT_MAX : DATAP + 1'b1;

    // Zero means "empty", so a zero score can never become the record, and a
    // tie does not rewrite reg7.
    assign new_best  = (s_reg != '0) && ((best == '0) || (s_reg < best));

    assign ready = (state == IDLE);

    // While busy the displays keep the address captured in the last idle
    // cycle, so they never show a slot in the middle of being rewritten.
    assign RQ = ready ? view_ptr : rq_hold;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and next write-port values.  The write port is registered, so
    // the values computed here describe the state being entered.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would infer a latch.
        state_d = state;
        wr_d    = 1'b0;
        wa_d    = REG_COUNT;
        ld_d    = '0;

        case (state)
            IDLE: begin
                if (score_valid) begin
                    state_d = W_SCORE;
                    wr_d    = 1'b1;
                    wa_d    = slot_ptr;
                    ld_d    = score_in;
                end
            end
            W_SCORE: begin
                state_d = W_COUNT;
                wr_d    = 1'b1;
                wa_d    = REG_COUNT;
                ld_d    = count_inc;
            end
            W_COUNT: begin
                state_d = W_BEST;
                if (new_best) begin
                    wr_d = 1'b1;
                    wa_d = REG_BEST;
                    ld_d = s_reg;
                end
            end
            W_BEST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            WR      <= 1'b0;
            WA      <= REG_COUNT;
            LD_DATA <= '0;
            s_reg   <= '0;
            best    <= '0;
            rq_hold <= REG_FIRST_SLOT;
            dropped <= 1'b0;
        end else begin
            WR      <= wr_d;
            WA      <= wa_d;
            LD_DATA <= ld_d;
            dropped <= score_valid && (state != IDLE);

            if (state == IDLE && score_valid) begin
                s_reg <= score_in;
            end

            // best follows reg7: it changes on the same edge the write lands.
            if (state == W_BEST && WR) begin
                best <= LD_DATA;
            end

            if (state == IDLE) begin
                rq_hold <= view_ptr;
            end
        end
    end

endmodule

// File: tb/tb_score_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_score_bank_sequencer
// Self-checking bench for score_bank_sequencer.  The bench plays the register
// file (so DATAP follows reg0 unless overridden) and keeps a run-level model:
// number of runs, number of stored scores, record time and display position.
// Each accepted score is turned into the list of writes it must produce and the
// DUT's four post-acceptance cycles are compared against it.
// -----------------------------------------------------------------------------
module tb_score_bank_sequencer;

    localparam int NSLOTS = 4;
    localparam int W      = 13;
    localparam int CMAX   = (1 << W) - 1;

    logic         Clock = 1'b0;
    logic         CLRN;
    logic         score_valid;
    logic [W-1:0] score_in;
    logic         view_next;
    logic [W-1:0] DATAP;
    logic         WR;
    logic [2:0]   WA;
    logic [W-1:0] LD_DATA;
    logic [2:0]   RQ;
    logic         ready;
    logic         dropped;
    logic [W-1:0] best;

    score_bank_sequencer #(.NSLOTS(NSLOTS), .W(W)) dut (
        .Clock       (Clock),
        .CLRN        (CLRN),
        .score_valid (score_valid),
        .score_in    (score_in),
        .view_next   (view_next),
        .DATAP       (DATAP),
        .WR          (WR),
        .WA          (WA),
        .LD_DATA     (LD_DATA),
        .RQ          (RQ),
        .ready       (ready),
        .dropped     (dropped),
        .best        (best)
    );

    always #10 Clock = ~Clock;

    // Register file stand-in, cleared by the same reset line.
    logic [W-1:0] rf [8];
    bit           force_en;
    logic [W-1:0] force_val;

    always @(posedge Clock) begin
        if (!CLRN) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (WR) begin
            rf[WA] <= LD_DATA;
        end
    end

    assign DATAP = force_en ? force_val : rf[0];

    int n_checks = 0;
    int n_errors = 0;

    // Observations of the four cycles following acceptance of a score.
    logic         obs_wr    [4];
    logic [2:0]   obs_wa    [4];
    logic [W-1:0] obs_d     [4];
    logic         obs_ready [4];
    logic         obs_drop  [4];
    logic [2:0]   obs_rq    [4];
    logic [W-1:0] obs_best  [4];

    // Expectations produced by the model.
    logic         exp_wr [4];
    logic [2:0]   exp_wa [4];
    logic [W-1:0] exp_d  [4];
    logic [2:0]   exp_rq_busy;
    logic [2:0]   exp_rq_idle;
    logic [W-1:0] exp_best;

    // Run-level model state.
    int           m_runs;
    int           m_stored;
    int           m_view;
    logic [W-1:0] m_best;

    function automatic logic [2:0] view_code(input int idx);
        return (idx < NSLOTS) ? 3'(idx + 1) : 3'd7;
    endfunction

    task automatic model_reset();
        m_runs   = 0;
        m_stored = 0;
        m_view   = 0;
        m_best   = '0;
    endtask

    task automatic model_score(input logic [W-1:0] v, input int n_view);
        int base;
        int cnt;
        base = force_en ? int'(force_val) : m_runs;
        cnt  = (base + 1 > CMAX) ? CMAX : base + 1;
        exp_rq_busy = view_code(m_view);
        for (int k = 0; k < 4; k++) begin
            exp_wr[k] = 1'b0;
            exp_wa[k] = 3'd0;
            exp_d[k]  = '0;
        end
        exp_wr[0] = 1'b1;
        exp_wa[0] = 3'((m_stored % NSLOTS) + 1);
        exp_d[0]  = v;
        exp_wr[1] = 1'b1;
        exp_wa[1] = 3'd0;
        exp_d[1]  = W'(cnt);
        if (v != 0 && (m_best == 0 || v < m_best)) begin
            exp_wr[2] = 1'b1;
            exp_wa[2] = 3'd7;
            exp_d[2]  = v;
            m_best    = v;
        end
        m_stored++;
        m_runs      = cnt;
        m_view      = (m_view + n_view) % (NSLOTS + 1);
        exp_rq_idle = view_code(m_view);
        exp_best    = m_best;
    endtask

    task automatic do_reset(input int n);
        @(negedge Clock);
        CLRN = 1'b0;
        score_valid = 1'b0;
        view_next = 1'b0;
        repeat (n) @(negedge Clock);
        CLRN = 1'b1;
        model_reset();
    endtask

    // Offer one score and record the next four cycles.  ov adds a second
    // score_valid one cycle later; vn_first pulses view_next together with
    // score_valid; vn_mask[k] pulses view_next after observation k.
    task automatic do_score(input logic [W-1:0] v, input bit ov, input bit vn_first,
                            input logic [2:0] vn_mask);
        @(negedge Clock);
        score_valid = 1'b1;
        score_in    = v;
        view_next   = vn_first;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            obs_wr[k]    = WR;
            obs_wa[k]    = WA;
            obs_d[k]     = LD_DATA;
            obs_ready[k] = ready;
            obs_drop[k]  = dropped;
            obs_rq[k]    = RQ;
            obs_best[k]  = best;
            score_valid  = (k == 0) && ov;
            score_in     = ((k == 0) && ov) ? ~v : v;
            view_next    = (k < 3) ? vn_mask[k] : 1'b0;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        CLRN = 1'b0;
        score_valid = 1'b0;
        score_in = '0;
        view_next = 1'b0;
        force_en = 1'b0;
        force_val = '0;
        repeat (2) @(negedge Clock);
        CLRN = 1'b1;
        model_reset();
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (WR !== 1'b0) begin n_errors++; $display("FAIL reset_wr: got %b want 0", WR); end
        n_checks++; if (RQ !== 3'd1) begin n_errors++; $display("FAIL reset_rq: got %0d want 1", RQ); end
        n_checks++; if (best !== '0) begin n_errors++; $display("FAIL reset_best: got %0d want 0", best); end
        n_checks++; if (dropped !== 1'b0) begin n_errors++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    endtask

    task automatic test_first_run();
        model_score(13'd250, 0);
        do_score(13'd250, 1'b0, 1'b0, 3'b000);
        n_checks++; if ({obs_wr[0], obs_wa[0], obs_d[0]} !== {1'b1, 3'd1, 13'd250})
            begin n_errors++; $display("FAIL first_score: got wr=%b wa=%0d d=%0d want 1/1/250", obs_wr[0], obs_wa[0], obs_d[0]); end
        n_checks++; if ({obs_wr[1], obs_wa[1], obs_d[1]} !== {1'b1, 3'd0, 13'd1})
            begin n_errors++; $display("FAIL first_count: got wr=%b wa=%0d d=%0d want 1/0/1", obs_wr[1], obs_wa[1], obs_d[1]); end
        n_checks++; if ({obs_wr[2], obs_wa[2], obs_d[2]} !== {1'b1, 3'd7, 13'd250})
            begin n_errors++; $display("FAIL first_best_wr: got wr=%b wa=%0d d=%0d want 1/7/250", obs_wr[2], obs_wa[2], obs_d[2]); end
        n_checks++; if ({obs_ready[0], obs_ready[1], obs_ready[2], obs_ready[3]} !== 4'b0001)
            begin n_errors++; $display("FAIL first_ready: got %b%b%b%b want 0001", obs_ready[0], obs_ready[1], obs_ready[2], obs_ready[3]); end
        n_checks++; if (obs_wr[3] !== 1'b0) begin n_errors++; $display("FAIL first_idle_wr: got %b want 0", obs_wr[3]); end
        n_checks++; if (obs_best[3] !== 13'd250) begin n_errors++; $display("FAIL first_best: got %0d want 250", obs_best[3]); end
    endtask

    task automatic test_wrap_best();
        logic [W-1:0] dir_v    [5];
        logic [W-1:0] dir_best [5];
        logic [W-1:0] v;
        bit           vf;
        logic [2:0]   vm;
        dir_v    = '{13'd300, 13'd180, 13'd400, 13'd500, 13'd90};
        dir_best = '{13'd300, 13'd180, 13'd180, 13'd180, 13'd90};
        do_reset(2);
        for (int i = 0; i < 29; i++) begin
            if (i < 5) begin
                v = dir_v[i]; vf = 1'b0; vm = 3'b000;
            end else begin
                v  = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom_range(1, 2000));
                vf = 1'($urandom_range(0, 1));
                vm = 3'($urandom_range(0, 7));
            end
            model_score(v, int'(vf) + $countones(vm));
            do_score(v, 1'b0, vf, vm);
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (obs_wr[k] !== exp_wr[k])
                    begin n_errors++; $display("FAIL run%0d_wr%0d: got %b want %b", i, k, obs_wr[k], exp_wr[k]); end
                if (exp_wr[k]) begin
                    n_checks++; if (obs_wa[k] !== exp_wa[k] || obs_d[k] !== exp_d[k])
                        begin n_errors++; $display("FAIL run%0d_write%0d: got wa=%0d d=%0d want wa=%0d d=%0d", i, k, obs_wa[k], obs_d[k], exp_wa[k], exp_d[k]); end
                end
                n_checks++; if (obs_ready[k] !== logic'(k == 3))
                    begin n_errors++; $display("FAIL run%0d_ready%0d: got %b want %b", i, k, obs_ready[k], (k == 3)); end
                n_checks++; if (obs_rq[k] !== ((k < 3) ? exp_rq_busy : exp_rq_idle))
                    begin n_errors++; $display("FAIL run%0d_rq%0d: got %0d want %0d", i, k, obs_rq[k], (k < 3) ? exp_rq_busy : exp_rq_idle); end
                n_checks++; if (obs_drop[k] !== 1'b0)
                    begin n_errors++; $display("FAIL run%0d_dropped%0d: got %b want 0", i, k, obs_drop[k]); end
            end
            n_checks++; if (obs_best[3] !== exp_best)
                begin n_errors++; $display("FAIL run%0d_best: got %0d want %0d", i, obs_best[3], exp_best); end
            if (i < 5) begin
                n_checks++; if (obs_best[3] !== dir_best[i])
                    begin n_errors++; $display("FAIL dir%0d_best: got %0d want %0d", i, obs_best[3], dir_best[i]); end
            end
            if (i == 4) begin
                n_checks++; if (obs_wa[0] !== 3'd1)
                    begin n_errors++; $display("FAIL wrap_slot: got %0d want 1", obs_wa[0]); end
            end
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] v;
        int           n_wr;
        int           n_exp;
        v = W'($urandom_range(1, 2000));
        model_score(v, 0);
        do_score(v, 1'b1, 1'b0, 3'b000);
        n_wr = 0;
        n_exp = 0;
        for (int k = 0; k < 4; k++) begin
            n_wr += int'(obs_wr[k]);
            n_exp += int'(exp_wr[k]);
            if (exp_wr[k]) begin
                n_checks++; if (obs_wr[k] !== 1'b1 || obs_wa[k] !== exp_wa[k] || obs_d[k] !== exp_d[k])
                    begin n_errors++; $display("FAIL overrun_write%0d: got wr=%b wa=%0d d=%0d want wa=%0d d=%0d", k, obs_wr[k], obs_wa[k], obs_d[k], exp_wa[k], exp_d[k]); end
            end
        end
        n_checks++; if ({obs_drop[0], obs_drop[1], obs_drop[2], obs_drop[3]} !== 4'b0100)
            begin n_errors++; $display("FAIL overrun_dropped: got %b%b%b%b want 0100", obs_drop[0], obs_drop[1], obs_drop[2], obs_drop[3]); end
        n_checks++; if (n_wr !== n_exp)
            begin n_errors++; $display("FAIL overrun_write_count: got %0d want %0d", n_wr, n_exp); end
        repeat (2) begin
            @(negedge Clock);
            n_checks++; if (WR !== 1'b0 || ready !== 1'b1 || dropped !== 1'b0)
                begin n_errors++; $display("FAIL overrun_idle: got wr=%b ready=%b dropped=%b want 0/1/0", WR, ready, dropped); end
        end
        v = W'($urandom_range(1, 2000));
        model_score(v, 0);
        do_score(v, 1'b0, 1'b0, 3'b000);
        n_checks++; if (obs_wa[0] !== exp_wa[0] || obs_d[0] !== v)
            begin n_errors++; $display("FAIL overrun_next_slot: got wa=%0d d=%0d want wa=%0d d=%0d", obs_wa[0], obs_d[0], exp_wa[0], v); end
    endtask

    task automatic test_saturation();
        logic [W-1:0] v;
        force_en = 1'b1;
        force_val = 13'd8191;
        v = W'($urandom_range(1, 2000));
        model_score(v, 0);
        do_score(v, 1'b0, 1'b0, 3'b000);
        n_checks++; if (obs_wa[1] !== 3'd0 || obs_d[1] !== 13'd8191 || obs_d[1] !== exp_d[1])
            begin n_errors++; $display("FAIL sat_full: got wa=%0d d=%0d want 0/8191", obs_wa[1], obs_d[1]); end
        force_val = 13'd8190;
        model_score(v, 0);
        do_score(v, 1'b0, 1'b0, 3'b000);
        n_checks++; if (obs_d[1] !== 13'd8191)
            begin n_errors++; $display("FAIL sat_edge: got %0d want 8191", obs_d[1]); end
        force_val = 13'd100;
        model_score(v, 0);
        do_score(v, 1'b0, 1'b0, 3'b000);
        n_checks++; if (obs_d[1] !== exp_d[1])
            begin n_errors++; $display("FAIL sat_normal: got %0d want %0d", obs_d[1], exp_d[1]); end
        force_en = 1'b0;
    endtask

    task automatic test_view_and_abort();
        logic [2:0] rq_list [5];
        rq_list = '{3'd2, 3'd3, 3'd4, 3'd7, 3'd1};
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            view_next = 1'b1;
            @(negedge Clock);
            view_next = 1'b0;
            m_view = (m_view + 1) % (NSLOTS + 1);
            n_checks++; if (RQ !== rq_list[i] || RQ !== view_code(m_view))
                begin n_errors++; $display("FAIL view_step%0d: got %0d want %0d", i, RQ, rq_list[i]); end
        end
        // View pulses with the score and during the busy cycles.
        model_score(13'd120, 4);
        do_score(13'd120, 1'b0, 1'b1, 3'b111);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (obs_rq[k] !== exp_rq_busy)
                begin n_errors++; $display("FAIL view_busy%0d: got %0d want %0d", k, obs_rq[k], exp_rq_busy); end
        end
        n_checks++; if (obs_rq[3] !== exp_rq_idle || obs_rq[3] !== 3'd7)
            begin n_errors++; $display("FAIL view_after_busy: got %0d want %0d", obs_rq[3], exp_rq_idle); end
        n_checks++; if (obs_wr[0] !== 1'b1 || obs_d[0] !== 13'd120)
            begin n_errors++; $display("FAIL view_same_cycle_score: got wr=%b d=%0d want 1/120", obs_wr[0], obs_d[0]); end
        // Reset while the count write is on the port.
        @(negedge Clock);
        score_valid = 1'b1;
        score_in = 13'd77;
        @(negedge Clock);
        score_valid = 1'b0;
        @(negedge Clock);
        n_checks++; if (WR !== 1'b1 || WA !== 3'd0)
            begin n_errors++; $display("FAIL abort_setup: got wr=%b wa=%0d want 1/0", WR, WA); end
        CLRN = 1'b0;
        @(negedge Clock);
        n_checks++; if (WR !== 1'b0 || ready !== 1'b1 || best !== '0 || RQ !== 3'd1)
            begin n_errors++; $display("FAIL abort_reset: got wr=%b ready=%b best=%0d rq=%0d want 0/1/0/1", WR, ready, best, RQ); end
        CLRN = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            n_checks++; if (WR !== 1'b0 || ready !== 1'b1)
                begin n_errors++; $display("FAIL abort_quiet%0d: got wr=%b ready=%b want 0/1", i, WR, ready); end
        end
    endtask

    initial begin
        test_reset();
        test_first_run();
        test_wrap_best();
        test_overrun();
        test_saturation();
        test_view_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
